// File: rtl/muldiv_pkg.sv
// Shared constants for the HI/LO multiply/divide sequencer:
// op codes, FSM state encoding, default widths and an op-class helper.
package muldiv_pkg;

  localparam int DW_DEF         = 32;
  localparam int DIV_CYCLES_DEF = 32;

  localparam logic [3:0] OP_MULT  = 4'd0;
  localparam logic [3:0] OP_MULTU = 4'd1;
  localparam logic [3:0] OP_DIV   = 4'd2;
  localparam logic [3:0] OP_DIVU  = 4'd3;
  localparam logic [3:0] OP_MTHI  = 4'd4;
  localparam logic [3:0] OP_MTLO  = 4'd5;
  localparam logic [3:0] OP_MADD  = 4'd6;
  localparam logic [3:0] OP_MADDU = 4'd7;
  localparam logic [3:0] OP_MSUB  = 4'd8;
  localparam logic [3:0] OP_MSUBU = 4'd9;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_MUL      = 3'd1,
    S_DIV_PREP = 3'd2,
    S_DIV_ITER = 3'd3,
    S_DIV_FIX  = 3'd4
  } state_t;

  function automatic logic op_is_madd(input logic [3:0] o);
    return (o == OP_MADD) || (o == OP_MADDU) ||
           (o == OP_MSUB) || (o == OP_MSUBU);
  endfunction

endpackage

// File: rtl/div_step.sv
// One combinational restoring-divide step.
// In: partial remainder, next dividend bit, divisor. Out: next remainder, quotient bit.
module div_step #(
  parameter int DW = 32
) (
  input  logic [DW-1:0] rem_i,
  input  logic          dvd_bit_i,
  input  logic [DW-1:0] dvs_i,
  output logic [DW-1:0] rem_o,
  output logic          q_o
);

  logic [DW:0] sh;
  logic [DW:0] diff;
  logic        unused_diff_msb;

  always_comb begin
    sh    = {rem_i, dvd_bit_i};
    diff  = sh - {1'b0, dvs_i};
    q_o   = (sh >= {1'b0, dvs_i});
    // remainder stays below the divisor, so DW bits always hold it
    rem_o = q_o ? diff[DW-1:0] : sh[DW-1:0];
  end

  assign unused_diff_msb = diff[DW];

endmodule

// File: rtl/hilo_muldiv_ctrl.sv
// HI/LO sequencer: 1-cycle multiply, radix-2 restoring divide, MTHI/MTLO.
// Ports: clk/rst_n, start/op/opa/opb/flush in, busy/done, HI/LO write and read ports.
// Optional MADD/MSUB family enabled by macro HILO_MULDIV_MADD_EN.
module hilo_muldiv_ctrl
  import muldiv_pkg::*;
#(
  parameter int DW         = DW_DEF,
  parameter int DIV_CYCLES = DIV_CYCLES_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [3:0]    op,
  input  logic [DW-1:0] opa,
  input  logic [DW-1:0] opb,
  input  logic          flush,
  output logic          busy,
  output logic          done,
  output logic          wehi,
  output logic [DW-1:0] wdatahi,
  output logic          welo,
  output logic [DW-1:0] wdatalo,
  output logic          rehi,
  output logic          relo,
  input  logic [DW-1:0] rdatahi,
  input  logic [DW-1:0] rdatalo
);

  localparam int CW = $clog2(DIV_CYCLES + 1);

  state_t          state_q, state_d;
  logic [CW-1:0]   count_q, count_d;
  logic [3:0]      op_q, op_d;
  logic [DW-1:0]   a_q, a_d;
  logic [DW-1:0]   b_q, b_d;
  logic [DW-1:0]   dvd_q, dvd_d;
  logic [DW-1:0]   dvs_q, dvs_d;
  logic [DW-1:0]   rem_q, rem_d;
  logic            nq_q, nq_d;
  logic            nr_q, nr_d;
  logic            dz_q, dz_d;
  logic            done_q, done_d;
  logic            wehi_q, wehi_d;
  logic            welo_q, welo_d;
  logic [DW-1:0]   whi_q, whi_d;
  logic [DW-1:0]   wlo_q, wlo_d;

  logic            legal;
  logic            accept;
  logic            mul_sgn;
  logic [2*DW-1:0] ax, bx, prod, res;
  logic [DW-1:0]   step_rem;
  logic            step_q;
  logic [DW-1:0]   q_fix, r_fix;
  logic            sgn_div;

  assign busy    = (state_q != S_IDLE);
  assign done    = done_q;
  assign wehi    = wehi_q;
  assign welo    = welo_q;
  assign wdatahi = whi_q;
  assign wdatalo = wlo_q;

`ifdef HILO_MULDIV_MADD_EN
  assign legal = (op <= OP_MSUBU);
`else
  assign legal = (op <= OP_MTLO);
`endif

  assign accept = start & ~busy & ~flush & legal;

  div_step #(.DW(DW)) u_div_step (
    .rem_i     (rem_q),
    .dvd_bit_i (dvd_q[DW-1]),
    .dvs_i     (dvs_q),
    .rem_o     (step_rem),
    .q_o       (step_q)
  );

  // state register plus datapath flops
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      count_q <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      rem_q   <= '0;
      nq_q    <= 1'b0;
      nr_q    <= 1'b0;
      dz_q    <= 1'b0;
      done_q  <= 1'b0;
      wehi_q  <= 1'b0;
      welo_q  <= 1'b0;
      whi_q   <= '0;
      wlo_q   <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      rem_q   <= rem_d;
      nq_q    <= nq_d;
      nr_q    <= nr_d;
      dz_q    <= dz_d;
      done_q  <= done_d;
      wehi_q  <= wehi_d;
      welo_q  <= welo_d;
      whi_q   <= whi_d;
      wlo_q   <= wlo_d;
    end
  end

  // next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (op == OP_DIV || op == OP_DIVU) begin
            state_d = S_DIV_PREP;
          end else if (op != OP_MTHI && op != OP_MTLO) begin
            state_d = S_MUL;
          end
        end
      end
      S_MUL:      state_d = S_IDLE;
      S_DIV_PREP: state_d = S_DIV_ITER;
      S_DIV_ITER: begin
        if (count_q == CW'(DIV_CYCLES - 1)) begin
          state_d = S_DIV_FIX;
        end
      end
      S_DIV_FIX:  state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
    if (flush) begin
      state_d = S_IDLE;
    end
  end

  // multiply / accumulate result
  always_comb begin
    mul_sgn = (op_q == OP_MULT) || (op_q == OP_MADD) ||
              (op_q == OP_MSUB);
    ax   = mul_sgn ? {{DW{a_q[DW-1]}}, a_q} : {{DW{1'b0}}, a_q};
    bx   = mul_sgn ? {{DW{b_q[DW-1]}}, b_q} : {{DW{1'b0}}, b_q};
    prod = ax * bx;
    res  = prod;
    rehi = 1'b0;
    relo = 1'b0;
`ifdef HILO_MULDIV_MADD_EN
    if (op_is_madd(op_q)) begin
      if (op_q == OP_MSUB || op_q == OP_MSUBU) begin
        res = {rdatahi, rdatalo} - prod;
      end else begin
        res = {rdatahi, rdatalo} + prod;
      end
      rehi = (state_q == S_MUL);
      relo = (state_q == S_MUL);
    end
`endif
  end

`ifndef HILO_MULDIV_MADD_EN
  logic unused_rd;
  assign unused_rd = ^{rdatahi, rdatalo};
`endif

  // outputs and datapath updates
  always_comb begin
    count_d = count_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    rem_d   = rem_q;
    nq_d    = nq_q;
    nr_d    = nr_q;
    dz_d    = dz_q;
    done_d  = 1'b0;
    wehi_d  = 1'b0;
    welo_d  = 1'b0;
    whi_d   = whi_q;
    wlo_d   = wlo_q;
    sgn_div = (op_q == OP_DIV);
    q_fix   = nq_q ? -dvd_q : dvd_q;
    r_fix   = nr_q ? -rem_q : rem_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          op_d = op;
          a_d  = opa;
          b_d  = opb;
          if (op == OP_MTHI) begin
            wehi_d = 1'b1;
            whi_d  = opa;
            done_d = 1'b1;
          end else if (op == OP_MTLO) begin
            welo_d = 1'b1;
            wlo_d  = opa;
            done_d = 1'b1;
          end
        end
      end
      S_MUL: begin
        if (!flush) begin
          wehi_d = 1'b1;
          welo_d = 1'b1;
          done_d = 1'b1;
          whi_d  = res[2*DW-1:DW];
          wlo_d  = res[DW-1:0];
        end
      end
      S_DIV_PREP: begin
        dvd_d   = (sgn_div & a_q[DW-1]) ? -a_q : a_q;
        dvs_d   = (sgn_div & b_q[DW-1]) ? -b_q : b_q;
        rem_d   = '0;
        count_d = '0;
        nq_d    = sgn_div & (a_q[DW-1] ^ b_q[DW-1]);
        nr_d    = sgn_div & a_q[DW-1];
        dz_d    = (b_q == '0);
      end
      S_DIV_ITER: begin
        rem_d   = step_rem;
        // dividend register doubles as the quotient shift register
        dvd_d   = {dvd_q[DW-2:0], step_q};
        count_d = count_q + CW'(1);
      end
      S_DIV_FIX: begin
        if (!flush) begin
          wehi_d = 1'b1;
          welo_d = 1'b1;
          done_d = 1'b1;
          whi_d  = dz_q ? a_q : r_fix;
          wlo_d  = dz_q ? '1  : q_fix;
        end
      end
      default: ;
    endcase
  end

endmodule
